// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared types and defaults for the IO bus master.
//   state_e      - bus master FSM states
//   io_req_t     - queued request {write, addr, data}
//   IO_IDLE_ADDR - unmapped address parked on the bus between accesses
package io_bus_pkg;

  localparam int IO_ADDR_W = 16;
  localparam int IO_DATA_W = 16;
  localparam logic [IO_ADDR_W-1:0] IO_IDLE_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef struct packed {
    logic                 write;
    logic [IO_ADDR_W-1:0] addr;
    logic [IO_DATA_W-1:0] data;
  } io_req_t;

endpackage

// File: rtl/io_bus_master_if.sv
// io_bus_master_if: core request/response channels plus the IO bus.
//   req_*  core -> master request channel (valid/ready)
//   rsp_*  master -> core read response channel (valid/ready)
//   io_*   master <-> peripheral bus (addr, wdata, write strobe, rdata)
//   busy   master has queued or in-flight work
// Handshake: a transfer happens on the rising clk edge where valid and
// ready are both high. The sender holds valid and its payload stable until
// that edge; ready may change freely and never depends on a future valid.
interface io_bus_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_write;
  logic [DATA_W-1:0] io_rdata;
  logic              busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, io_rdata,
    output req_ready, rsp_valid, rsp_rdata, io_addr, io_wdata, io_write, busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, io_rdata,
    input  req_ready, rsp_valid, rsp_rdata, io_addr, io_wdata, io_write, busy
  );
endinterface

// File: rtl/io_req_fifo.sv
// io_req_fifo: synchronous request FIFO, async active-low reset.
//   push_i/push_data_i  write an entry (ignored when full)
//   pop_i               drop the head entry (ignored when empty)
//   head_o              current head entry
//   full_o/empty_o      occupancy flags
// Pointers carry one extra wrap bit: equal pointers mean empty, equal
// indices with differing wrap bits mean full. DEPTH must be a power of two.
module io_req_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/io_bus_master.sv
// io_bus_master: queues core read/write requests and drives them onto the
// IO bus in order. Reads are captured one cycle after their bus cycle
// (peripheral has registered read data) and returned on the rsp channel.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         io_bus_master_if.master (req_*, rsp_*, io_*, busy)
//   dbg_state   current FSM state
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int                ADDR_W     = IO_ADDR_W,
  parameter int                DATA_W     = IO_DATA_W,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] IDLE_ADDR  = IO_IDLE_ADDR
) (
  input  logic             clk,
  input  logic             rst_n,
  io_bus_master_if.master  bus,
  output state_e           dbg_state
);
  io_req_t           push_req, head_req;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] io_addr_q, io_addr_d;
  logic [DATA_W-1:0] io_wdata_q, io_wdata_d;
  logic              io_write_q, io_write_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  assign push_req  = '{write: bus.req_write, addr: bus.req_addr, data: bus.req_wdata};
  // No pass-through: a full queue refuses even when it is popped this cycle.
  assign fifo_push = bus.req_valid && !fifo_full;

  io_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(io_req_t))
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (push_req),
    .pop_i       (fifo_pop),
    .head_o      (head_req),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // State register (bus and response registers ride along).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      io_addr_q   <= IDLE_ADDR;
      io_wdata_q  <= '0;
      io_write_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      io_addr_q   <= io_addr_d;
      io_wdata_q  <= io_wdata_d;
      io_write_q  <= io_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state logic. In BUS, io_write_q tells whether the access on the
  // bus is a write, so no separate copy of the request type is kept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = BUS;
      BUS: begin
        if (!io_write_q)     state_d = CAPTURE;
        else if (fifo_empty) state_d = IDLE;
      end
      CAPTURE: state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = fifo_empty ? IDLE : BUS;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: FIFO pop and next values of the bus/response registers.
  always_comb begin
    fifo_pop    = 1'b0;
    io_addr_d   = IDLE_ADDR;
    io_wdata_d  = '0;
    io_write_d  = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE:    fifo_pop = !fifo_empty;
      BUS:     fifo_pop = io_write_q && !fifo_empty;
      CAPTURE: begin
        rsp_rdata_d = bus.io_rdata;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          fifo_pop    = !fifo_empty;
        end
      end
      default: fifo_pop = 1'b0;
    endcase
    // Every pop loads the popped entry onto the bus for the next cycle;
    // reads park write data at zero.
    if (fifo_pop) begin
      io_addr_d  = head_req.addr;
      io_wdata_d = head_req.write ? head_req.data : '0;
      io_write_d = head_req.write;
    end
  end

  assign bus.req_ready = !fifo_full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.io_addr   = io_addr_q;
  assign bus.io_wdata  = io_wdata_q;
  assign bus.io_write  = io_write_q;
  assign bus.busy      = !fifo_empty || (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master: directed bench for io_bus_master with a registered
// peripheral model, an expected-response queue and a bus write log.
module tb_io_bus_master;
  import io_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;
  always #5 clk = ~clk;

  io_bus_master_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  io_bus_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- peripheral model ----------------
  logic [15:0] pmem [16] = '{1: 16'h5000, 2: 16'h1234, 6: 16'h6666, default: 16'h0000};
  always @(posedge clk) begin
    if (bus.io_write) pmem[bus.io_addr[3:0]] <= bus.io_wdata;
    bus.io_rdata <= (bus.io_addr == 16'hFFFF) ? 16'h0000 : pmem[bus.io_addr[3:0]];
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  typedef struct {
    int          c;
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;
  wr_t wr_log[$];
  wr_t wr_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.io_write) begin
      wr_e.c = cyc;
      wr_e.a = bus.io_addr;
      wr_e.d = bus.io_wdata;
      wr_log.push_back(wr_e);
    end
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", {31'b0, bus.rsp_valid}, 32'd0);
      else                   check("rsp_data", {16'b0, bus.rsp_rdata}, {16'b0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge
  // (start of cycle 1 relative to acceptance).
  task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
      if (n > 50) begin
        check("send_accept", {31'b0, bus.req_ready}, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    // Power-on reset values
    repeat (2) @(negedge clk);
    check("rst_io_addr",   bus.io_addr,   32'hFFFF);
    check("rst_io_wdata",  bus.io_wdata,  32'h0);
    check("rst_io_write",  bus.io_write,  32'h0);
    check("rst_rsp_valid", bus.rsp_valid, 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_busy",      bus.busy,      32'h0);
    check("rst_req_ready", bus.req_ready, 32'h1);
    check("rst_state",     dbg_state,     IDLE);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", bus.req_ready, 32'h1);
    check("post_rst_io_addr",   bus.io_addr,   32'hFFFF);
    next_cycle();

    // Single write: bus shows it in cycle 2 only
    send(1'b1, 16'h0000, 16'h00A5);
    @(negedge clk);
    check("wr_c1_io_write", bus.io_write, 32'h0);
    check("wr_c1_busy",     bus.busy,     32'h1);
    @(negedge clk);
    check("wr_c2_io_addr",  bus.io_addr,  32'h0);
    check("wr_c2_io_wdata", bus.io_wdata, 32'h00A5);
    check("wr_c2_io_write", bus.io_write, 32'h1);
    check("wr_c2_rsp",      bus.rsp_valid, 32'h0);
    @(negedge clk);
    check("wr_c3_io_write", bus.io_write, 32'h0);
    check("wr_c3_io_addr",  bus.io_addr,  32'hFFFF);
    check("wr_c3_periph",   pmem[0],      32'h00A5);
    @(negedge clk);
    check("wr_c4_rsp",      bus.rsp_valid, 32'h0);
    check("wr_c4_busy",     bus.busy,      32'h0);
    next_cycle();

    // Single read: rsp_valid in cycle 4 with peripheral data
    exp_q.push_back(16'h5000);
    send(1'b0, 16'h0001, 16'hBEEF);
    @(negedge clk);
    @(negedge clk);
    check("rd_c2_io_addr",  bus.io_addr,  32'h0001);
    check("rd_c2_io_write", bus.io_write, 32'h0);
    check("rd_c2_io_wdata", bus.io_wdata, 32'h0);
    @(negedge clk);
    check("rd_c3_rsp_valid", bus.rsp_valid, 32'h0);
    check("rd_c3_io_write",  bus.io_write,  32'h0);
    check("rd_c3_io_addr",   bus.io_addr,   32'hFFFF);
    @(negedge clk);
    check("rd_c4_rsp_valid", bus.rsp_valid, 32'h1);
    check("rd_c4_rsp_rdata", bus.rsp_rdata, 32'h5000);
    check("rd_c4_io_write",  bus.io_write,  32'h0);
    @(negedge clk);
    check("rd_c5_rsp_valid", bus.rsp_valid, 32'h0);
    check("rd_c5_busy",      bus.busy,      32'h0);
    next_cycle();

    // Backpressure: read held in RESP, FIFO fills, third request refused
    bus.rsp_ready = 1'b0;
    exp_q.push_back(16'h1234);
    send(1'b0, 16'h0002, 16'h0000);
    send(1'b1, 16'h0003, 16'h0011);
    send(1'b1, 16'h0004, 16'h0022);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h0005;
    bus.req_wdata = 16'h0033;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req_ready_full", bus.req_ready, 32'h0);
      next_cycle();
    end
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_rsp_valid_hold", bus.rsp_valid, 32'h1);
      check("bp_rsp_rdata_hold", bus.rsp_rdata, 32'h1234);
      check("bp_bus_idle",       bus.io_addr,   32'hFFFF);
      next_cycle();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_rsp_valid_hs", bus.rsp_valid, 32'h1);
    @(negedge clk);
    check("bp_drain1_rsp",   bus.rsp_valid, 32'h0);
    check("bp_drain1_addr",  bus.io_addr,   32'h0003);
    check("bp_drain1_wdata", bus.io_wdata,  32'h0011);
    check("bp_drain1_write", bus.io_write,  32'h1);
    @(negedge clk);
    check("bp_drain2_addr",  bus.io_addr,   32'h0004);
    check("bp_drain2_wdata", bus.io_wdata,  32'h0022);
    check("bp_drain2_write", bus.io_write,  32'h1);
    @(negedge clk);
    check("bp_done_addr",    bus.io_addr,   32'hFFFF);
    check("bp_done_write",   bus.io_write,  32'h0);
    check("bp_done_busy",    bus.busy,      32'h0);
    check("bp_refused_wr",   pmem[5],       32'h0);
    next_cycle();

    // Burst: three back-to-back writes, no idle gap
    wr_log.delete();
    send(1'b1, 16'h0000, 16'h0001);
    send(1'b1, 16'h0000, 16'h0002);
    send(1'b1, 16'h0000, 16'h0003);
    repeat (4) @(negedge clk);
    check("burst_count", wr_log.size(), 32'd3);
    if (wr_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("burst_addr",  {16'b0, wr_log[i].a}, 32'h0);
        check("burst_wdata", {16'b0, wr_log[i].d}, i + 1);
        check("burst_gap",   wr_log[i].c - wr_log[0].c, i);
      end
    end
    check("burst_idle_addr", bus.io_addr, 32'hFFFF);
    check("burst_periph",    pmem[0],     32'h0003);
    next_cycle();

    // Reset in CAPTURE with one entry queued
    send(1'b0, 16'h0006, 16'h0000);
    send(1'b1, 16'h0007, 16'h0077);
    @(negedge clk);
    check("rr_c2_state", dbg_state,   BUS);
    check("rr_c2_addr",  bus.io_addr, 32'h0006);
    next_cycle();
    @(negedge clk);
    check("rr_c3_state", dbg_state, CAPTURE);
    #1 rst_n = 1'b0;
    #1;
    check("rr_rsp_valid", bus.rsp_valid, 32'h0);
    check("rr_busy",      bus.busy,      32'h0);
    check("rr_io_addr",   bus.io_addr,   32'hFFFF);
    check("rr_io_write",  bus.io_write,  32'h0);
    check("rr_req_ready", bus.req_ready, 32'h1);
    check("rr_state",     dbg_state,     IDLE);
    wr_log.delete();
    next_cycle();
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rr_no_issue",    wr_log.size(), 32'd0);
    check("rr_periph_7",    pmem[7],       32'h0);
    check("rr_rsp_after",   bus.rsp_valid, 32'h0);
    check("rr_busy_after",  bus.busy,      32'h0);
    check("exp_q_drained",  exp_q.size(),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
